// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data lane select and sign/zero extension.
module load_ext
  import wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // off[0] is ignored for halfwords: misaligned accesses trap upstream
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the result source, waits on load responses and drives
// a registered register-file write pulse; aborts loads that never answer.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_rd_wren_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic [31:0] ex_alu_data_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [2:0]  ex_ld_funct3_i,
  input  logic [1:0]  ex_ld_off_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  localparam int unsigned CntW = $clog2(LOAD_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(LOAD_TIMEOUT - 1);

  wb_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_wren_q, ld_wren_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            wren_q, wren_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;

  logic            accept;
  logic [31:0]     nonload_data;
  logic [31:0]     load_data;

  assign ex_ready_o = (state_q == IDLE) && rst_ni;
  assign accept     = ex_valid_i && ex_ready_o;

  load_ext u_load_ext (
    .funct3 (ld_f3_q),
    .off    (ld_off_q),
    .word   (dmem_rdata_i),
    .result (load_data)
  );

  always_comb begin
    case (wb_sel_e'(ex_wb_sel_i))
      WB_PC4:  nonload_data = ex_pc_i + 32'd4;
      WB_IMM:  nonload_data = ex_imm_i;
      default: nonload_data = ex_alu_data_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_wren_d = ld_wren_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb_sel_e'(ex_wb_sel_i) == WB_LOAD) begin
            ld_rd_d   = ex_rd_addr_i;
            ld_wren_d = ex_rd_wren_i;
            ld_f3_d   = ex_ld_funct3_i;
            ld_off_d  = ex_ld_off_i;
            cnt_d     = '0;
            state_d   = WAIT_LOAD;
          end else if (ex_rd_wren_i && (ex_rd_addr_i != 5'd0)) begin
            wren_d = 1'b1;
            addr_d = ex_rd_addr_i;
            data_d = nonload_data;
          end
        end
      end
      WAIT_LOAD: begin
        // A response on the threshold cycle still wins over the timeout
        if (dmem_rvalid_i) begin
          if (ld_wren_q && (ld_rd_q != 5'd0)) begin
            wren_d = 1'b1;
            addr_d = ld_rd_q;
            data_d = load_data;
          end
          state_d = IDLE;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_wren_q <= 1'b0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_wren_q <= ld_wren_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign rd_wren_o = wren_q;
  assign rd_addr_o = addr_q;
  assign rd_data_o = data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_wb_stage;

  localparam int unsigned LT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_rd_wren;
  logic [4:0]  ex_rd_addr;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu, ex_pc, ex_imm;
  logic [2:0]  ex_f3;
  logic [1:0]  ex_off;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rd_wren, err;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  wb_stage #(.LOAD_TIMEOUT(LT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .ex_rd_wren_i   (ex_rd_wren),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_wb_sel_i    (ex_wb_sel),
    .ex_alu_data_i  (ex_alu),
    .ex_pc_i        (ex_pc),
    .ex_imm_i       (ex_imm),
    .ex_ld_funct3_i (ex_f3),
    .ex_ld_off_i    (ex_off),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .rd_wren_o      (rd_wren),
    .rd_addr_o      (rd_addr),
    .rd_data_o      (rd_data),
    .err_o          (err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * int'(off));
    b  = sh[7:0];
    sh = w >> (16 * int'(off[1]));
    h  = sh[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [4:0]  p_rd;
  logic        p_wren;
  logic [2:0]  p_f3;
  logic [1:0]  p_off;
  logic        exp_wren = 1'b0, exp_err = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; exp_wren = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    end else begin
      exp_wren = 1'b0;
      exp_err  = 1'b0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (ex_wb_sel == 2'd1) begin
            m_busy = 1'b1; m_wait = 0;
            p_rd = ex_rd_addr; p_wren = ex_rd_wren; p_f3 = ex_f3; p_off = ex_off;
          end else if (ex_rd_wren && ex_rd_addr != 0) begin
            exp_wren = 1'b1;
            exp_addr = ex_rd_addr;
            exp_data = (ex_wb_sel == 2'd0) ? ex_alu :
                       (ex_wb_sel == 2'd2) ? ex_pc + 32'd4 : ex_imm;
          end
        end
      end else begin
        m_wait++;
        if (dmem_rvalid) begin
          m_busy = 1'b0;
          if (p_wren && p_rd != 0) begin
            exp_wren = 1'b1; exp_addr = p_rd; exp_data = m_ext(p_f3, p_off, dmem_rdata);
          end
        end else if (m_wait == int'(LT)) begin
          m_busy  = 1'b0;
          exp_err = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, well after the edge
  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      check("cyc_wren",  {31'd0, rd_wren}, {31'd0, exp_wren});
      check("cyc_err",   {31'd0, err}, {31'd0, exp_err});
      check("cyc_ready", {31'd0, ex_ready}, {31'd0, rst_n && !m_busy});
      check("cyc_addr",  {27'd0, rd_addr}, {27'd0, exp_addr});
      check("cyc_data",  rd_data, exp_data);
      check("cyc_excl",  {31'd0, rd_wren && err}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic wren,
                    input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                    input logic [2:0] f3, input logic [1:0] off);
    ex_valid = 1'b1; ex_wb_sel = sel; ex_rd_addr = rd; ex_rd_wren = wren;
    ex_alu = alu; ex_pc = pc; ex_imm = imm; ex_f3 = f3; ex_off = off;
  endtask

  // Load with `gap` empty wait cycles before the response
  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] rd, input int gap, input logic [31:0] word,
                         input logic [31:0] exp);
    op(2'd1, rd, 1'b1, 32'h0, 32'h0, 32'h0, f3, off);
    nxt();
    ex_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      check({name, "_busy"}, {31'd0, ex_ready}, 32'd0);
      nxt();
    end
    check({name, "_busy"}, {31'd0, ex_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = word;
    nxt();
    dmem_rvalid = 1'b0;
    check({name, "_wren"}, {31'd0, rd_wren}, 32'd1);
    check({name, "_data"}, rd_data, exp);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_ready"}, {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd_wren = 1'b0; ex_rd_addr = '0; ex_wb_sel = '0;
    ex_alu = '0; ex_pc = '0; ex_imm = '0; ex_f3 = '0; ex_off = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    nxt(); nxt();
    chk_en = 1'b1;
    check("rst_wren", {31'd0, rd_wren}, 32'd0);
    check("rst_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b1;

    // Single ALU op
    op(2'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 2'd0);
    nxt();
    ex_valid = 1'b0;
    check("alu_wren", {31'd0, rd_wren}, 32'd1);
    check("alu_addr", {27'd0, rd_addr}, 32'd5);
    check("alu_data", rd_data, 32'h1234_5678);
    nxt();
    check("alu_wren_off", {31'd0, rd_wren}, 32'd0);
    check("alu_data_hold", rd_data, 32'h1234_5678);

    // JAL with wrapping PC+4, then rd=0
    op(2'd2, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0, 2'd0);
    nxt();
    check("jal_wren", {31'd0, rd_wren}, 32'd1);
    check("jal_data", rd_data, 32'h0);
    op(2'd2, 5'd0, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0, 2'd0);
    nxt();
    ex_valid = 1'b0;
    check("jal_x0_wren", {31'd0, rd_wren}, 32'd0);

    // LUI
    op(2'd3, 5'd3, 1'b1, 32'h0, 32'h0, 32'hABCD_E000, 3'd0, 2'd0);
    nxt();
    ex_valid = 1'b0;
    check("lui_data", rd_data, 32'hABCD_E000);

    do_load("lb",  3'd0, 2'd3, 5'd7, 2, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 2'd3, 5'd7, 2, 32'h80FF_0000, 32'h0000_0080);
    do_load("lhu", 3'd5, 2'd2, 5'd7, 2, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lh",  3'd1, 2'd3, 5'd8, 0, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lw4", 3'd2, 2'd1, 5'd8, int'(LT) - 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Timeout: no response
    op(2'd1, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
    nxt();
    ex_valid = 1'b0;
    for (int i = 0; i < int'(LT); i++) begin
      check("to_busy", {31'd0, ex_ready}, 32'd0);
      check("to_noerr", {31'd0, err}, 32'd0);
      nxt();
    end
    check("to_err", {31'd0, err}, 32'd1);
    check("to_nowrite", {31'd0, rd_wren}, 32'd0);
    check("to_ready", {31'd0, ex_ready}, 32'd1);
    nxt();
    check("to_err_once", {31'd0, err}, 32'd0);

    // Reset in the 2nd wait cycle with a response present
    op(2'd1, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
    nxt();
    ex_valid = 1'b0;
    nxt();
    rst_n = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    nxt();
    check("rl_wren", {31'd0, rd_wren}, 32'd0);
    check("rl_addr", {27'd0, rd_addr}, 32'd0);
    check("rl_data", rd_data, 32'd0);
    check("rl_err", {31'd0, err}, 32'd0);
    check("rl_ready", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b1; dmem_rvalid = 1'b0;
    nxt();
    check("rl_idle", {31'd0, ex_ready}, 32'd1);
    check("rl_nowrite", {31'd0, rd_wren}, 32'd0);

    // Back-to-back ALU ops, a load, then a held ALU op
    for (int k = 0; k < 3; k++) begin
      op(2'd0, 5'(10 + k), 1'b1, 32'h1000 + 32'(k), 32'h0, 32'h0, 3'd0, 2'd0);
      nxt();
      check("b2b_wren", {31'd0, rd_wren}, 32'd1);
      check("b2b_data", rd_data, 32'h1000 + 32'(k));
    end
    op(2'd1, 5'd20, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
    nxt();
    check("b2b_ld_nowrite", {31'd0, rd_wren}, 32'd0);
    check("b2b_ld_busy", {31'd0, ex_ready}, 32'd0);
    op(2'd0, 5'd21, 1'b1, 32'h0000_ABCD, 32'h0, 32'h0, 3'd0, 2'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    nxt();
    dmem_rvalid = 1'b0;
    check("b2b_ld_data", rd_data, 32'hCAFE_F00D);
    check("b2b_ld_addr", {27'd0, rd_addr}, 32'd20);
    nxt();
    ex_valid = 1'b0;
    check("b2b_held_addr", {27'd0, rd_addr}, 32'd21);
    check("b2b_held_data", rd_data, 32'h0000_ABCD);
    nxt();
    check("b2b_quiet", {31'd0, rd_wren}, 32'd0);

    // Randomized traffic; execute holds its inputs while stalled
    for (int c = 0; c < 3000; c++) begin
      if (!(ex_valid && !ex_ready)) begin
        op(2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(0, 5) != 0),
           $urandom, ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        ex_valid = ($urandom_range(0, 3) != 0);
      end
      dmem_rvalid = ($urandom_range(0, 3) == 0);
      dmem_rdata  = $urandom;
      rst_n       = ($urandom_range(0, 99) != 0);
      nxt();
    end
    rst_n = 1'b1; ex_valid = 1'b0; dmem_rvalid = 1'b0;
    nxt(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
